// File: rtl/rasterizer_if.sv
// Command-bus types and the CPU<->GPU rasterizer interface.
// The command encoding lives here so both sides of the bus share one definition.
package common;
    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_FILL  = 3'd1,
        CMD_POINT = 3'd2,
        CMD_LINE  = 3'd3,
        CMD_RECT  = 3'd4
    } raster_command_t;
endpackage

// Handshake: the CPU raises execute_request with command fields valid; the GPU
// takes it on any rising edge where busy is 0 and holds busy high until done.
interface rasterizer_if;
    common::raster_command_t command;
    logic [7:0]              x0;
    logic [7:0]              y0;
    logic [7:0]              x1;
    logic [7:0]              y1;
    logic [2:0]              colour;
    logic                    execute_request;
    logic                    busy;

    modport gpu (
        input  command, x0, y0, x1, y1, colour, execute_request,
        output busy
    );

    modport cpu (
        output command, x0, y0, x1, y1, colour, execute_request,
        input  busy
    );
endinterface

// File: rtl/rasterizer.sv
// Walks the pixels of FILL/POINT/RECT/LINE commands one per cycle and issues
// framebuffer writes, skipping off-screen pixels in a single cycle each.
module rasterizer
    import common::*;
#(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    rasterizer_if.gpu         gpu_if,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_write,
    input  logic              fb_ready
);

    typedef enum logic {S_IDLE = 1'b0, S_DRAW = 1'b1} state_t;

    localparam logic [8:0] W_LIM = 9'(FB_WIDTH);
    localparam logic [8:0] H_LIM = 9'(FB_HEIGHT);

    state_t             state_q, state_d;
    logic               is_line_q, is_line_d;
    logic [7:0]         cx_q, cx_d;
    logic [7:0]         cy_q, cy_d;
    logic [7:0]         xmin_q, xmin_d;
    logic [7:0]         xmax_q, xmax_d;
    logic [7:0]         ymax_q, ymax_d;
    logic [7:0]         dx_q, dx_d;
    logic signed [9:0]  dy_q, dy_d;
    logic signed [9:0]  err_q, err_d;
    logic               xneg_q, xneg_d;
    logic               yneg_q, yneg_d;
    logic [2:0]         colour_q, colour_d;

    logic               cmd_valid;
    logic               start;
    logic               visible;
    logic               last_px;
    logic               advance;
    logic signed [10:0] e2;
    logic               step_x;
    logic               step_y;
    logic [7:0]         adx;
    logic [7:0]         ady;
    logic signed [9:0]  err_step;

    // For LINE, xmax/ymax hold the end point so the same "last pixel" test serves all commands.
    assign cmd_valid = gpu_if.command inside {CMD_FILL, CMD_POINT, CMD_LINE, CMD_RECT};
    assign start     = (state_q == S_IDLE) && gpu_if.execute_request && cmd_valid;
    assign visible   = ({1'b0, cx_q} < W_LIM) && ({1'b0, cy_q} < H_LIM);
    assign last_px   = (cx_q == xmax_q) && (cy_q == ymax_q);
    assign advance   = (state_q == S_DRAW) && (!visible || fb_ready);

    assign e2     = {err_q, 1'b0};
    assign step_x = e2 >= $signed({dy_q[9], dy_q});
    assign step_y = e2 <= $signed({3'b000, dx_q});
    assign adx    = (gpu_if.x1 >= gpu_if.x0) ? gpu_if.x1 - gpu_if.x0 : gpu_if.x0 - gpu_if.x1;
    assign ady    = (gpu_if.y1 >= gpu_if.y0) ? gpu_if.y1 - gpu_if.y0 : gpu_if.y0 - gpu_if.y1;

    assign fb_addr = ADDR_W'(cy_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(cx_q);
    assign fb_data = colour_q;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_line_q <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymax_q    <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            xneg_q    <= 1'b0;
            yneg_q    <= 1'b0;
            colour_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_line_q <= is_line_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymax_q    <= ymax_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            xneg_q    <= xneg_d;
            yneg_q    <= yneg_d;
            colour_q  <= colour_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_DRAW;
            S_DRAW:  if (advance && last_px) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        gpu_if.busy = (state_q == S_DRAW);
        fb_write    = (state_q == S_DRAW) && visible;
    end

    // Datapath: command setup at acceptance, pixel stepping on each consumed pixel
    always_comb begin
        is_line_d = is_line_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymax_d    = ymax_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        xneg_d    = xneg_q;
        yneg_d    = yneg_q;
        colour_d  = colour_q;
        err_step  = err_q;

        if (start) begin
            colour_d  = gpu_if.colour;
            is_line_d = 1'b0;
            case (gpu_if.command)
                CMD_FILL: begin
                    cx_d   = '0;
                    cy_d   = '0;
                    xmin_d = '0;
                    xmax_d = 8'(FB_WIDTH - 1);
                    ymax_d = 8'(FB_HEIGHT - 1);
                end
                CMD_POINT: begin
                    cx_d   = gpu_if.x0;
                    cy_d   = gpu_if.y0;
                    xmin_d = gpu_if.x0;
                    xmax_d = gpu_if.x0;
                    ymax_d = gpu_if.y0;
                end
                CMD_RECT: begin
                    xmin_d = (gpu_if.x0 < gpu_if.x1) ? gpu_if.x0 : gpu_if.x1;
                    xmax_d = (gpu_if.x0 < gpu_if.x1) ? gpu_if.x1 : gpu_if.x0;
                    cy_d   = (gpu_if.y0 < gpu_if.y1) ? gpu_if.y0 : gpu_if.y1;
                    ymax_d = (gpu_if.y0 < gpu_if.y1) ? gpu_if.y1 : gpu_if.y0;
                    cx_d   = xmin_d;
                end
                CMD_LINE: begin
                    is_line_d = 1'b1;
                    cx_d      = gpu_if.x0;
                    cy_d      = gpu_if.y0;
                    xmax_d    = gpu_if.x1;
                    ymax_d    = gpu_if.y1;
                    dx_d      = adx;
                    dy_d      = -$signed({2'b00, ady});
                    err_d     = $signed({2'b00, adx}) - $signed({2'b00, ady});
                    xneg_d    = gpu_if.x1 < gpu_if.x0;
                    yneg_d    = gpu_if.y1 < gpu_if.y0;
                end
                default: ;
            endcase
        end else if (advance && !last_px) begin
            if (is_line_q) begin
                if (step_x) begin
                    err_step = err_step + dy_q;
                    cx_d     = xneg_q ? cx_q - 8'd1 : cx_q + 8'd1;
                end
                if (step_y) begin
                    err_step = err_step + $signed({2'b00, dx_q});
                    cy_d     = yneg_q ? cy_q - 8'd1 : cy_q + 8'd1;
                end
                err_d = err_step;
            end else if (cx_q == xmax_q) begin
                cx_d = xmin_q;
                cy_d = cy_q + 8'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/rasterizer.md
# rasterizer

Rasterizer that sits on the GPU side of `rasterizer_if`, directly downstream of the CPU's rasterizer controller. It accepts one draw command at a time (FILL, POINT, LINE, RECT) with two 8-bit corner coordinates and a 3-bit colour. It walks the covered pixels one per cycle and issues framebuffer writes, clipping anything off-screen. While a command is in progress it reports busy back to the CPU.

## Interface
Parameters:
- `FB_WIDTH`, default 160: visible columns.
- `FB_HEIGHT`, default 120: visible rows.
- `ADDR_W`, default 15: framebuffer address width (must hold `FB_WIDTH*FB_HEIGHT-1`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gpu_if`  `rasterizer_if.gpu`  —  command bus from the CPU:
  - `command`: `common::raster_command_t`, encoding 0 NOP, 1 FILL, 2 POINT, 3 LINE, 4 RECT; other values are treated as NOP.
  - `x0`, `y0`, `x1`, `y1`: 8 bits each.
  - `colour`: 3 bits.
  - `execute_request`: in.
  - `busy`: out.
- `fb_addr`  out  `ADDR_W`  pixel address, computed as `y*FB_WIDTH + x`.
- `fb_data`  out  3  pixel colour.
- `fb_write`  out  1  write strobe.
- `fb_ready`  in  1  framebuffer accepts the write this cycle.

## Operation
- **States.**
  - IDLE. `busy`=0.
  - DRAW. `busy`=1.
- **Acceptance.** In IDLE, `execute_request`=1 on a rising edge latches `command`, coordinates and `colour`.
  - If the command is not NOP, move to DRAW.
  - NOP and unknown commands leave the block in IDLE with no writes.
  - `execute_request` is ignored while in DRAW.
- **Current pixel.** The pixel (cx,cy) is held in registers.
  - `fb_addr` and `fb_data` are combinational from the registers.
  - `fb_write` = DRAW && cx<`FB_WIDTH` && cy<`FB_HEIGHT`.
- **Advancing.**
  - A visible pixel advances only on an edge with `fb_write`&`fb_ready`.
  - A clipped pixel advances unconditionally after one cycle, with no write.
- **FILL.** Ignores coordinates.
  - Starts at (0,0) and goes x-major: x increments, and at `FB_WIDTH-1` wraps to 0 and y increments.
  - Ends after (`FB_WIDTH-1`,`FB_HEIGHT-1`), i.e. 19200 pixels by default.
- **POINT.** A single pixel at (x0,y0).
- **RECT.** Corners are normalised at acceptance:
  - xmin=min(x0,x1), xmax=max(x0,x1); likewise for y.
  - Scan is x-major from (xmin,ymin) to (xmax,ymax) inclusive: (xmax−xmin+1)·(ymax−ymin+1) pixels.
- **LINE.** Integer Bresenham from (x0,y0) to (x1,y1), both endpoints inclusive.
  - dx=|x1−x0|, dy=−|y1−y0|, sx/sy=±1.
  - err is signed 10-bit, initialised to dx+dy.
  - Per step, e2=2·err (11-bit signed):
    - if e2≥dy: err+=dy, x+=sx;
    - if e2≤dx: err+=dx, y+=sy.
  - Both updates apply in the same step when both conditions hold.
  - Ends after the pixel equal to (x1,y1) is consumed.
  - Pixel count is max(dx,|dy|)+1.
- **Completion.** When the last pixel is consumed (written, or skipped if clipped), return to IDLE.
- **Arithmetic.**
  - Coordinates are unsigned 8-bit. Internal cx/cy are 8-bit with no wrap; the endpoint tests prevent overflow.
  - Address multiply is `y*128 + y*32 + x` for the default width; generic `y*FB_WIDTH + x` is acceptable.
- **Reset.** `rst_n` low at any time, including mid-draw, forces IDLE immediately. The in-progress command is abandoned and no further writes occur.

## Timing
- Reset values: `busy`=0, `fb_write`=0, `fb_addr`=0, `fb_data`=0; all registers are 0.
- Accept at edge N. `busy`=1 and the first pixel is presented in cycle N+1.
- With `fb_ready` held high, the block produces one pixel per cycle.
  - The command occupies exactly P cycles of `busy`, where P is the pixel count.
  - `busy` falls in the cycle after the last pixel is consumed.
- A new request can be accepted on the edge where `busy` is already 0, giving a one-cycle minimum gap between commands.
- `fb_write`, `fb_addr` and `fb_data` stay stable while `fb_ready`=0.
- A stall has no timeout.

## Test plan
- **POINT.** (5,3), colour 6 → exactly one write, `fb_addr`=485, `fb_data`=6; `busy` high for 1 cycle.
- **RECT with reversed corners.** (10,10)-(8,9), colour 2 → 6 writes in this order: 1448, 1449, 1450, 1608, 1609, 1610; `busy` high for 6 cycles.
- **LINE.** (0,0)-(3,1) → writes in this order: (0,0), (1,0), (2,1), (3,1), i.e. addresses 0, 1, 162, 163.
- **LINE with stalls.** (3,1)-(0,0) with `fb_ready` low for 2 cycles mid-line → same 4 pixels, each held stable through its stall.
- **Clipping.**
  - POINT (200,5) → no write; `busy` high for 1 cycle.
  - RECT (158,0)-(161,0) → writes to 158 and 159 only; `busy` high for 4 cycles.
- **FILL with random `fb_ready`.** → exactly 19200 writes, addresses 0..19199 in order; a request issued mid-fill is ignored.
- **Reset mid-FILL.** Assert `rst_n`=0 after 100 writes → `busy` and `fb_write` drop to 0 immediately. A following POINT then works normally.
